fnd_share_arb: RTL and testbench
================================

FND_SHARE_ARB -- requirements
Module: fnd_share_arb

Interface
REQ-001 Parameter MIN_HOLD, default 1000, minimum number of clk cycles an owner keeps the display before it can be preempted by a waiting requester.
REQ-002 Parameter IDLE_PATTERN, default 16'h0000, 4-nibble value driven on hex_out when no requester owns the display.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  system clock, same clock that drives fnd4digit.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_a  input  1  requester A wants the display; level-sensitive, held high while in use.
REQ-007 data_a  input  16  requester A digits; [3:0]=rightmost digit, [15:12]=leftmost.
REQ-008 req_b  input  1  requester B wants the display; level-sensitive.
REQ-009 data_b  input  16  requester B digits, same nibble order as data_a.
REQ-010 grant_a  output  1  requester A currently owns the display.
REQ-011 grant_b  output  1  requester B currently owns the display.
REQ-012 hex_out  output  16  digits to fnd4digit: [3:0]->hexValue, [7:4]->hexValue2, [11:8]->hexValue3, [15:12]->hexValue4.
REQ-013 busy  output  1  high whenever either grant is high.

Function
REQ-014 FSM states SHALL be IDLE, OWN_A, OWN_B; all outputs SHALL be registered.
REQ-015 grant_a/grant_b SHALL be one-hot-or-zero in every cycle; never both high.
REQ-016 IDLE: req_a only -> OWN_A next cycle; req_b only -> OWN_B; both -> side opposite last_owner; neither -> stay IDLE.
REQ-017 last_owner SHALL be a 1-bit pointer updated on every entry to OWN_A/OWN_B; reset value = B, so A wins the first tie.
REQ-018 Grant latency: req sampled high at edge N in IDLE -> grant high after edge N+1 (one cycle).
REQ-019 hold_cnt: 16-bit, cleared to 0 on every state change, incremented each cycle in OWN_x, saturates at MIN_HOLD.
REQ-020 OWN_x, own req drops, other req high -> switch directly to other OWN state next cycle, regardless of hold_cnt.
REQ-021 OWN_x, own req drops, other req low -> IDLE next cycle.
REQ-022 OWN_x, own req high, other req high, hold_cnt==MIN_HOLD -> switch to other OWN state next cycle (time-slicing).
REQ-023 OWN_x, own req high, other req high, hold_cnt<MIN_HOLD -> stay; other requester waits.
REQ-024 hex_out SHALL load data_x of the next-state owner each cycle (hex_out at N+1 = data_x at N); next state IDLE -> IDLE_PATTERN.
REQ-025 A switch SHALL never produce a cycle where hex_out mixes nibbles of both requesters.
REQ-026 MIN_HOLD=0 SHALL mean immediate alternation every cycle while both request.

Reset
REQ-027 While rst_n low: state=IDLE, grant_a=0, grant_b=0, busy=0, hex_out=IDLE_PATTERN, hold_cnt=0, last_owner=B.
REQ-028 Reset asserted mid-ownership SHALL drop grants immediately (asynchronously); after release, arbitration restarts from IDLE on the first clk edge.

Verification
REQ-029 Reset release, req_a=1, data_a=16'h1234 -> one cycle later grant_a=1, busy=1, hex_out=16'h1234.
REQ-030 IDLE, req_a=req_b=1 same edge after reset -> grant_a first; A drops req -> grant_b=1 next cycle, hex_out=data_b.
REQ-031 MIN_HOLD=4, A owns, B requests at hold_cnt=1 -> grant_a stays until hold_cnt=4, grant_b high on following cycle; grants never overlap.
REQ-032 A owns, req_a falls, req_b low -> next cycle grant_a=0, busy=0, hex_out=IDLE_PATTERN.
REQ-033 B owns with data_b=16'hBEEF, rst_n pulsed low mid-cycle -> grant_b=0 and hex_out=IDLE_PATTERN without waiting for clk.
REQ-034 MIN_HOLD=0, both req held high 8 cycles -> grants alternate A,B,A,B...; hex_out tracks the granted side every cycle.

Source files
------------

// File: rtl/fnd_share_arb_if.sv
// Display-sharing bundle between two requesters and the arbiter that
// owns the fnd4digit digit bus.
interface fnd_share_arb_if;
   logic        req_a;
   logic [15:0] data_a;
   logic        req_b;
   logic [15:0] data_b;
   logic        grant_a;
   logic        grant_b;
   logic        busy;
   logic [15:0] hex_out;

   modport master (
      output req_a, data_a, req_b, data_b,
      input  grant_a, grant_b, busy, hex_out
   );

   modport slave (
      input  req_a, data_a, req_b, data_b,
      output grant_a, grant_b, busy, hex_out
   );
endinterface

// File: rtl/fnd_share_arb.sv
// Two-requester arbiter for a shared 4-digit display: round-robin on ties,
// minimum-hold time slicing, and fully registered grant/digit outputs.
module fnd_share_arb #(
   parameter int unsigned MIN_HOLD     = 1000,
   parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
   input  logic            clk,
   input  logic            rst_n,
   fnd_share_arb_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;
   typedef enum logic       {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_e;

   localparam logic [15:0] HOLD_MAX = 16'(MIN_HOLD);

   state_e      state;
   state_e      state_next;
   owner_e      last_owner;
   logic [15:0] hold_cnt;
   logic [15:0] hex_next;
   logic        hold_done;

   assign hold_done = (hold_cnt == HOLD_MAX);

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      hex_next   = IDLE_PATTERN;

      case (state)
         IDLE: begin
            if (bus.req_a && bus.req_b)
               state_next = (last_owner == OWNER_B) ? OWN_A : OWN_B;
            else if (bus.req_a)
               state_next = OWN_A;
            else if (bus.req_b)
               state_next = OWN_B;
         end
         OWN_A: begin
            if (!bus.req_a)
               state_next = bus.req_b ? OWN_B : IDLE;
            else if (bus.req_b && hold_done)
               state_next = OWN_B;
         end
         OWN_B: begin
            if (!bus.req_b)
               state_next = bus.req_a ? OWN_A : IDLE;
            else if (bus.req_a && hold_done)
               state_next = OWN_A;
         end
         default: state_next = IDLE;
      endcase

      // Digits come whole from one side, chosen by the next owner.
      case (state_next)
         OWN_A:   hex_next = bus.data_a;
         OWN_B:   hex_next = bus.data_b;
         default: hex_next = IDLE_PATTERN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_owner  <= OWNER_B;
         hold_cnt    <= '0;
         bus.grant_a <= 1'b0;
         bus.grant_b <= 1'b0;
         bus.busy    <= 1'b0;
         bus.hex_out <= IDLE_PATTERN;
      end else begin
         state       <= state_next;
         bus.grant_a <= (state_next == OWN_A);
         bus.grant_b <= (state_next == OWN_B);
         bus.busy    <= (state_next != IDLE);
         bus.hex_out <= hex_next;

         if (state_next != state) begin
            hold_cnt <= '0;
            if (state_next == OWN_A)
               last_owner <= OWNER_A;
            else if (state_next == OWN_B)
               last_owner <= OWNER_B;
         end else if (state_next != IDLE && !hold_done) begin
            hold_cnt <= hold_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fnd_share_arb.sv
// Scoreboard bench: two arbiters (MIN_HOLD=4 and MIN_HOLD=0) share one
// stimulus stream and are compared against an ownership-rule model.
module tb_fnd_share_arb;

   localparam logic [15:0] IDLE4 = 16'hE0E0;
   localparam logic [15:0] IDLE0 = 16'h0000;

   typedef struct packed {
      logic        ga;
      logic        gb;
      logic        busy;
      logic [15:0] hex;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fnd_share_arb_if if4 ();
   fnd_share_arb_if if0 ();

   fnd_share_arb #(.MIN_HOLD(4), .IDLE_PATTERN(IDLE4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(if4.slave)
   );
   fnd_share_arb #(.MIN_HOLD(0), .IDLE_PATTERN(IDLE0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave)
   );

   exp_t q4[$];
   exp_t q0[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: owner 0 = nobody, 1 = A, 2 = B; held = completed cycles of tenure.
   int own  [2];
   int held [2];
   int last [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         own[d]  = 0;
         held[d] = 0;
         last[d] = 2;
      end
   endfunction

   function automatic exp_t model_step(input int d, input logic ra, input logic [15:0] da,
                                       input logic rb, input logic [15:0] db,
                                       input int min_hold, input logic [15:0] idle);
      int   cur;
      int   nxt;
      exp_t e;
      cur = own[d];
      nxt = cur;
      if (cur == 0) begin
         if (ra && rb)  nxt = (last[d] == 2) ? 1 : 2;
         else if (ra)   nxt = 1;
         else if (rb)   nxt = 2;
      end else begin
         logic mine;
         logic theirs;
         mine   = (cur == 1) ? ra : rb;
         theirs = (cur == 1) ? rb : ra;
         if (!mine)
            nxt = theirs ? 3 - cur : 0;
         else if (theirs && held[d] >= min_hold)
            nxt = 3 - cur;
      end
      if (nxt != cur) begin
         held[d] = 0;
         if (nxt != 0) last[d] = nxt;
      end else if (nxt != 0) begin
         held[d]++;
      end
      own[d] = nxt;
      e.ga   = (nxt == 1);
      e.gb   = (nxt == 2);
      e.busy = (nxt != 0);
      e.hex  = (nxt == 1) ? da : (nxt == 2) ? db : idle;
      return e;
   endfunction

   task automatic drive_now(input logic ra, input logic [15:0] da, input logic rb, input logic [15:0] db);
      if4.req_a = ra; if4.data_a = da; if4.req_b = rb; if4.data_b = db;
      if0.req_a = ra; if0.data_a = da; if0.req_b = rb; if0.data_b = db;
      q4.push_back(model_step(0, ra, da, rb, db, 4, IDLE4));
      q0.push_back(model_step(1, ra, da, rb, db, 0, IDLE0));
   endtask

   task automatic drive(input logic ra, input logic [15:0] da, input logic rb, input logic [15:0] db);
      @(negedge clk);
      drive_now(ra, da, rb, db);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " rst grant_a dut4"}, 32'(if4.grant_a), 32'd0);
      check({tag, " rst grant_b dut4"}, 32'(if4.grant_b), 32'd0);
      check({tag, " rst busy dut4"},    32'(if4.busy),    32'd0);
      check({tag, " rst hex dut4"},     32'(if4.hex_out), 32'(IDLE4));
      check({tag, " rst grant_a dut0"}, 32'(if0.grant_a), 32'd0);
      check({tag, " rst grant_b dut0"}, 32'(if0.grant_b), 32'd0);
      check({tag, " rst hex dut0"},     32'(if0.hex_out), 32'(IDLE0));
   endtask

   task automatic release_reset(input logic ra, input logic [15:0] da, input logic rb, input logic [15:0] db);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      drive_now(ra, da, rb, db);
   endtask

   // Asserts reset between clock edges and checks the outputs react at once.
   task automatic mid_cycle_reset(input string tag);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      q4.delete();
      q0.delete();
      repeat (2) @(posedge clk);
   endtask

   task automatic compare(input string tag, input logic ga, input logic gb, input logic bz,
                          input logic [15:0] hx, input exp_t e);
      check({tag, " grant_a"}, 32'(ga), 32'(e.ga));
      check({tag, " grant_b"}, 32'(gb), 32'(e.gb));
      check({tag, " busy"},    32'(bz), 32'(e.busy));
      check({tag, " hex_out"}, 32'(hx), 32'(e.hex));
      check({tag, " overlap"}, 32'(ga & gb), 32'd0);
   endtask

   // Monitor: outputs are valid every cycle out of reset.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && q4.size() != 0)
            compare("dut4", if4.grant_a, if4.grant_b, if4.busy, if4.hex_out, q4.pop_front());
         if (rst_n && q0.size() != 0)
            compare("dut0", if0.grant_a, if0.grant_b, if0.busy, if0.hex_out, q0.pop_front());
      end
   end

   initial begin
      logic        ra;
      logic        rb;
      rst_n = 1'b1;
      if4.req_a = 1'b0; if4.req_b = 1'b0; if4.data_a = '0; if4.data_b = '0;
      if0.req_a = 1'b0; if0.req_b = 1'b0; if0.data_a = '0; if0.data_b = '0;
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("power-on");
      repeat (3) @(posedge clk);

      // Tie straight out of reset goes to A, then B takes over when A drops.
      release_reset(1'b1, 16'hAAAA, 1'b1, 16'hBBBB);
      drive(1'b1, 16'hAAA1, 1'b1, 16'hBBB1);
      drive(1'b0, 16'hAAA2, 1'b1, 16'hBEEF);
      drive(1'b0, 16'hAAA3, 1'b1, 16'hBEEF);
      drive(1'b0, 16'hAAA4, 1'b1, 16'hBEEF);
      mid_cycle_reset("mid-B");

      // Single requester A, then A releases with B idle.
      release_reset(1'b1, 16'h1234, 1'b0, 16'h5678);
      drive(1'b1, 16'h1234, 1'b0, 16'h5678);
      drive(1'b1, 16'h4321, 1'b0, 16'h5678);
      drive(1'b0, 16'h4321, 1'b0, 16'h5678);
      drive(1'b0, 16'h0000, 1'b0, 16'h0000);

      // A owns, B arrives one cycle in, both held: slicing on dut4, alternation on dut0.
      drive(1'b1, 16'hA001, 1'b0, 16'hB001);
      drive(1'b1, 16'hA002, 1'b0, 16'hB002);
      for (int i = 0; i < 14; i++)
         drive(1'b1, 16'hA100 + 16'(i), 1'b1, 16'hB100 + 16'(i));
      drive(1'b0, 16'h0, 1'b0, 16'h0);
      drive(1'b0, 16'h0, 1'b0, 16'h0);

      // Randomized requests with persistence so holds and slices both occur.
      ra = 1'b0;
      rb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) ra = ~ra;
         if ($urandom_range(0, 7) == 0) rb = ~rb;
         drive(ra, 16'($urandom), rb, 16'($urandom));
         if (i == 1500) begin
            mid_cycle_reset("rand");
            release_reset(ra, 16'($urandom), rb, 16'($urandom));
         end
      end

      @(posedge clk);
      #2;
      check("dut4 queue drained", 32'(q4.size()), 32'd0);
      check("dut0 queue drained", 32'(q0.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
